// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner
// Purpose  : Time-multiplexed 4-digit hex display scanner with inter-digit
//            anode guard, blanking, decimal points and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
    parameter int REFRESH_CYCLES = 100000,
    parameter int GUARD_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic        load,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic        lz_en,
    output logic [3:0]  digit_data,
    output logic        dp_n,
    output logic [3:0]  anode_n,
    output logic [1:0]  digit_sel,
    output logic        frame_tick
);

    localparam int                   C_CNT_W = $clog2(REFRESH_CYCLES);
    localparam logic [C_CNT_W-1:0]   C_LAST  = C_CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [C_CNT_W-1:0]   C_GUARD = C_CNT_W'(GUARD_CYCLES);
    localparam logic [C_CNT_W-1:0]   C_ONE   = C_CNT_W'(1);

    logic [C_CNT_W-1:0] r_cnt;
    logic [1:0]         r_sel;
    logic [15:0]        r_data;
    logic [3:0]         r_dp;
    logic [3:0]         r_blank;
    logic               r_lz;

    logic               w_last;
    logic               w_guard;
    logic [3:0]         w_suppress;
    logic [3:0]         w_off;

    // Scan timing is independent of load so a display update never shifts
    // the refresh cadence.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_sel <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
            r_sel <= r_sel + 2'd1;
        end else begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_dp    <= '0;
            r_blank <= 4'b1111;
            r_lz    <= 1'b0;
        end else if (load) begin
            r_data  <= data;
            r_dp    <= dp;
            r_blank <= blank;
            r_lz    <= lz_en;
        end
    end

    assign w_last  = (r_cnt == C_LAST);
    assign w_guard = (r_cnt < C_GUARD);

    // A digit is a leading zero only if it and every digit to its left are zero;
    // the rightmost digit always shows so a zero value is still visible.
    assign w_suppress[3] = r_lz && (r_data[15:12] == 4'h0);
    assign w_suppress[2] = r_lz && (r_data[15:8]  == 8'h00);
    assign w_suppress[1] = r_lz && (r_data[15:4]  == 12'h000);
    assign w_suppress[0] = 1'b0;

    assign w_off = r_blank | w_suppress;

    always_comb begin
        anode_n = 4'b1111;
        dp_n    = 1'b1;
        if (!w_guard && !w_off[r_sel]) begin
            anode_n[r_sel] = 1'b0;
            dp_n           = ~r_dp[r_sel];
        end
    end

    assign digit_data = r_data[{r_sel, 2'b00} +: 4];
    assign digit_sel  = r_sel;
    assign frame_tick = w_last && (r_sel == 2'd3);

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_scanner
// Purpose  : Scoreboard bench for seven_segment_scanner (REFRESH=8, GUARD=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scanner;

    localparam int RC = 8;
    localparam int GC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  digit_data;
    logic        dp_n;
    logic [3:0]  anode_n;
    logic [1:0]  digit_sel;
    logic        frame_tick;

    always #5 clk = ~clk;

    seven_segment_scanner #(
        .REFRESH_CYCLES (RC),
        .GUARD_CYCLES   (GC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .load       (load),
        .dp         (dp),
        .blank      (blank),
        .lz_en      (lz_en),
        .digit_data (digit_data),
        .dp_n       (dp_n),
        .anode_n    (anode_n),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic       dpn;
        logic [3:0] dd;
        logic [1:0] sel;
        logic       ft;
    } exp_t;

    // Load vectors with hand-derived lit and decimal-point masks.
    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic        lz;
        logic [3:0]  lit;
        logic [3:0]  dpon;
    } vec_t;

    vec_t vecs [7];
    exp_t q [$];

    int          n_vec = 0;
    int          n_err = 0;
    int          m_cnt = 0;
    int          m_sel = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_lit = '0;
    logic [3:0]  m_dpon = '0;
    logic        prev_ft = 1'b0;

    initial begin
        vecs[0] = '{d:16'h1234, dp:4'b0100, bl:4'b0000, lz:1'b0, lit:4'b1111, dpon:4'b0100};
        vecs[1] = '{d:16'h0050, dp:4'b0000, bl:4'b0000, lz:1'b1, lit:4'b0011, dpon:4'b0000};
        vecs[2] = '{d:16'h0000, dp:4'b0000, bl:4'b0000, lz:1'b1, lit:4'b0001, dpon:4'b0000};
        vecs[3] = '{d:16'hABCD, dp:4'b1111, bl:4'b0101, lz:1'b0, lit:4'b1010, dpon:4'b1010};
        vecs[4] = '{d:16'h0007, dp:4'b1111, bl:4'b0000, lz:1'b1, lit:4'b0001, dpon:4'b0001};
        vecs[5] = '{d:16'h0100, dp:4'b0000, bl:4'b0000, lz:1'b1, lit:4'b0111, dpon:4'b0000};
        vecs[6] = '{d:16'h0000, dp:4'b1111, bl:4'b0000, lz:1'b0, lit:4'b1111, dpon:4'b1111};
    end

    task automatic push_expected();
        exp_t e;
        logic guard;
        guard  = (m_cnt < GC);
        e.an   = (guard || !m_lit[m_sel]) ? 4'b1111 : 4'(~(4'b0001 << m_sel));
        e.dpn  = !(!guard && m_dpon[m_sel]);
        e.dd   = m_data[m_sel*4 +: 4];
        e.sel  = 2'(m_sel);
        e.ft   = (m_cnt == RC - 1) && (m_sel == 3);
        q.push_back(e);
    endtask

    task automatic tick(input logic rs, input logic ld, input int vi);
        reset = rs;
        load  = ld;
        if (ld) begin
            data  = vecs[vi].d;
            dp    = vecs[vi].dp;
            blank = vecs[vi].bl;
            lz_en = vecs[vi].lz;
        end
        @(posedge clk);
        #1;
        if (rs) begin
            m_cnt  = 0;
            m_sel  = 0;
            m_data = '0;
            m_lit  = '0;
            m_dpon = '0;
        end else begin
            if (m_cnt == RC - 1) begin
                m_cnt = 0;
                m_sel = (m_sel + 1) % 4;
            end else begin
                m_cnt++;
            end
            if (ld) begin
                m_data = vecs[vi].d;
                m_lit  = vecs[vi].lit;
                m_dpon = vecs[vi].dpon;
            end
        end
        push_expected();
        reset = 1'b0;
        load  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if ({anode_n, dp_n, digit_data, digit_sel, frame_tick} !== e) begin
                n_err++;
                $display("FAIL outputs @%0t: got an=%b dpn=%b dd=%h sel=%0d ft=%b, expected an=%b dpn=%b dd=%h sel=%0d ft=%b",
                         $time, anode_n, dp_n, digit_data, digit_sel, frame_tick,
                         e.an, e.dpn, e.dd, e.sel, e.ft);
            end
            n_vec++;
            if ($countones(~anode_n) > 1) begin
                n_err++;
                $display("FAIL onehot_anode @%0t: got an=%b, expected at most one low bit", $time, anode_n);
            end
            n_vec++;
            if (frame_tick && prev_ft) begin
                n_err++;
                $display("FAIL frame_width @%0t: got frame_tick high 2 cycles, expected 1", $time);
            end
            prev_ft = frame_tick;
        end
    end

    initial begin
        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        idle(100);
        for (int v = 0; v < 6; v++) begin
            tick(1'b0, 1'b1, v);
            idle(40);
        end
        // Mid-period load during digit 1; vecs[5] has digit 1 = 0, vecs[0] = 3.
        for (int i = 0; i < 40 && !(m_sel == 1 && m_cnt == 4); i++) idle(1);
        tick(1'b0, 1'b1, 0);
        idle(40);
        tick(1'b0, 1'b1, 6);
        idle(12);
        // Reset and load together mid-scan: the load must be dropped.
        for (int i = 0; i < 40 && !(m_sel == 2 && m_cnt == 3); i++) idle(1);
        tick(1'b1, 1'b1, 3);
        idle(40);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
